vga_pixel_mixer: RTL and testbench
==================================

Name: vga_pixel_mixer

Overview:
Pixel-generation stage directly downstream of the VGA timing driver. Consumes the driver's latency-compensated request coordinates, disp flag and sync pulses. Drives read addresses to a background ROM (quarter resolution, vertically scrolling) and a player-plane sprite ROM. Composites sprite over background with a colour key and emits RGB plus syncs, all registered and mutually aligned, to the VGA pins.

Parameters:
H_DISP, 640, visible width in pixels
V_DISP, 480, visible height in lines
BG_W, 160, background ROM width (H_DISP/4)
BG_H, 120, background ROM height (V_DISP/4)
SPR_W, 64, sprite width
SPR_H, 64, sprite height
ROM_READ_DELAY, 2, cycles from req_*_addr_i to valid ROM data (1 address register + 1 BRAM read); must equal the driver's compensation
COLOR_W, 12, RGB444 pixel width
KEY_COLOR, 12'h000, transparent sprite colour

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
h_sync_i  in  1  driver line sync, active low
v_sync_i  in  1  driver frame sync, active low
disp_i  in  1  driver visible-area flag (aligned with ROM data arrival)
req_x_addr_i  in  10  requested column, ROM_READ_DELAY ahead of disp_i
req_y_addr_i  in  9  requested row
player_x_i  in  10  sprite top-left x, from game logic
player_y_i  in  9  sprite top-left y
scroll_en_i  in  1  advance background scroll once per frame
bg_addr_o  out  15  background ROM address
bg_data_i  in  COLOR_W  background ROM data
spr_addr_o  out  12  sprite ROM address
spr_data_i  in  COLOR_W  sprite ROM data
rgb_o  out  COLOR_W  pixel to DAC
h_sync_o  out  1  aligned line sync
v_sync_o  out  1  aligned frame sync
disp_o  out  1  aligned visible flag

Behaviour:
- Reset (async, rst_n low): all outputs 0 except h_sync_o=1, v_sync_o=1; bg_addr_o=0, spr_addr_o=0; scroll=0; shadow player regs=0; hit pipeline cleared.
- Frame event: v_sync_i 1->0 (registered edge detect). On that cycle: px_s<=player_x_i, py_s<=player_y_i; if scroll_en_i, scroll<=(scroll==BG_H-1)?0:scroll+1. Player coordinates change only here, never mid-frame.
- Stage A (registered, cycle t+1 from request t): bg row r=(req_y>>2)+scroll; if r>=BG_H subtract BG_H (one conditional subtract, both operands <BG_H). bg_addr_o=r*BG_W+(req_x>>2).
- Sprite hit: dx=req_x-px_s, dy=req_y-py_s computed one bit wider, signed; hit=dx>=0 && dx<SPR_W && dy>=0 && dy<SPR_H. Sprite partly off right/bottom edge clips, never wraps. spr_addr_o=hit ? dy*SPR_W+dx : 0.
- hit flag delayed ROM_READ_DELAY cycles total, arriving with bg_data_i/spr_data_i.
- Compose (cycle of data arrival): pix = (hit_d && spr_data_i!=KEY_COLOR) ? spr_data_i : bg_data_i; if !disp_i pix=0.
- Output register: rgb_o, disp_o, h_sync_o, v_sync_o registered together: total 1-cycle delay from driver syncs/disp to pins; rgb_o is 0 whenever disp_o=0.
- Out-of-range request (req beyond visible area, driver zeroes it): addresses computed normally; result masked by disp_i.
- Reset mid-frame: pipeline flushes to reset values; first valid frame begins at next v_sync_i falling edge for position latch, pixels valid immediately via disp_i.

Decomposition:
- Shared header: H_DISP/V_DISP, BG_W/BG_H, SPR_W/SPR_H, ROM_READ_DELAY, COLOR_W, KEY_COLOR, address widths; reuse existing display-length defines.
- One sub-module natural: sprite_hit_addr (dx/dy, hit test, sprite address, one register), reusable for enemy/bullet sprites.

Test Plan:
- Reset: rst_n=0 mid-line -> rgb_o=0, h_sync_o=v_sync_o=1, disp_o=0 immediately (asynchronous); bg_addr_o=0.
- Alignment: disp_i rising with bg ROM model returning address as data -> rgb_o equals bg_addr of req issued ROM_READ_DELAY+1 cycles earlier; syncs delayed exactly 1 cycle.
- Sprite key: px=100,py=50, req (100,50) spr_data=12'hF00 -> rgb_o=F00; (163,113) spr_addr=4095; (164,50) -> background; spr_data=000 inside -> background.
- Clip: px=600 -> req x=639 hits (dx=39); x=0 never hits; py=450, y=479 hits, no wrap.
- Scroll wrap: scroll_en_i=1 for 120 frames -> scroll 0..119 then 0; with scroll=119, req_y=4 -> bg row 0.
- Latch: player_x_i changed mid-frame -> composite unchanged until next v_sync_i falling edge.

Source files
------------

// File: rtl/vga_pixel_mixer_pkg.sv
// rtl/vga_pixel_mixer_pkg.sv - shared display, ROM and pixel definitions for the pixel mixer
package vga_pixel_mixer_pkg;

   localparam int H_DISP         = 640;
   localparam int V_DISP         = 480;
   localparam int BG_W           = H_DISP / 4;
   localparam int BG_H           = V_DISP / 4;
   localparam int SPR_W          = 64;
   localparam int SPR_H          = 64;
   localparam int ROM_READ_DELAY = 2;
   localparam int COLOR_W        = 12;

   localparam int X_W        = 10;
   localparam int Y_W        = 9;
   localparam int BG_ADDR_W  = 15;
   localparam int SPR_ADDR_W = 12;
   localparam int BG_ROW_W   = 7;

   typedef logic [COLOR_W-1:0] color_t;

   localparam color_t KEY_COLOR = 12'h000;

   typedef struct packed {
      color_t rgb;
      logic   h_sync;
      logic   v_sync;
      logic   disp;
   } pix_out_t;

   localparam pix_out_t PIX_OUT_RESET = '{rgb: '0, h_sync: 1'b1, v_sync: 1'b1, disp: 1'b0};

   // Both operands are below BG_H, so a single conditional subtract is a full modulo.
   function automatic logic [BG_ROW_W-1:0] bg_row_wrap(input logic [BG_ROW_W-1:0] row,
                                                       input logic [BG_ROW_W-1:0] scroll);
      logic [BG_ROW_W:0] sum;
      sum = {1'b0, row} + {1'b0, scroll};
      if (sum >= (BG_ROW_W+1)'(BG_H))
         sum = sum - (BG_ROW_W+1)'(BG_H);
      return sum[BG_ROW_W-1:0];
   endfunction

endpackage

// File: rtl/vga_pixel_mixer_if.sv
// rtl/vga_pixel_mixer_if.sv - background and sprite ROM read bus
interface vga_pixel_mixer_if;
   import vga_pixel_mixer_pkg::*;

   logic [BG_ADDR_W-1:0]  bg_addr;
   color_t                bg_data;
   logic [SPR_ADDR_W-1:0] spr_addr;
   color_t                spr_data;

   modport master (output bg_addr, output spr_addr, input bg_data, input spr_data);
   modport slave  (input bg_addr, input spr_addr, output bg_data, output spr_data);
endinterface

// File: rtl/vga_pixel_mixer_sprite_hit_addr.sv
// rtl/vga_pixel_mixer_sprite_hit_addr.sv - registered sprite hit test and sprite ROM address
module vga_pixel_mixer_sprite_hit_addr
   import vga_pixel_mixer_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [X_W-1:0]        req_x_i,
   input  logic [Y_W-1:0]        req_y_i,
   input  logic [X_W-1:0]        pos_x_i,
   input  logic [Y_W-1:0]        pos_y_i,
   output logic                  hit_o,
   output logic [SPR_ADDR_W-1:0] spr_addr_o
);
   localparam int SPR_XB = $clog2(SPR_W);
   localparam int SPR_YB = $clog2(SPR_H);

   logic signed [X_W:0]   dx;
   logic signed [Y_W:0]   dy;
   logic                  hit_d;
   logic                  hit_q;
   logic [SPR_ADDR_W-1:0] addr_d;
   logic [SPR_ADDR_W-1:0] addr_q;

   assign dx = $signed({1'b0, req_x_i}) - $signed({1'b0, pos_x_i});
   assign dy = $signed({1'b0, req_y_i}) - $signed({1'b0, pos_y_i});

   // Sprite sizes are powers of two: 0 <= d < size iff sign and upper bits are all zero.
   assign hit_d  = (dx[X_W:SPR_XB] == '0) && (dy[Y_W:SPR_YB] == '0);
   assign addr_d = hit_d ? {dy[SPR_YB-1:0], dx[SPR_XB-1:0]} : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_q  <= 1'b0;
         addr_q <= '0;
      end else begin
         hit_q  <= hit_d;
         addr_q <= addr_d;
      end
   end

   assign hit_o      = hit_q;
   assign spr_addr_o = addr_q;
endmodule

// File: rtl/vga_pixel_mixer.sv
// rtl/vga_pixel_mixer.sv - scrolling background plus keyed sprite compositor feeding the VGA pins
module vga_pixel_mixer
   import vga_pixel_mixer_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              h_sync_i,
   input  logic              v_sync_i,
   input  logic              disp_i,
   input  logic [X_W-1:0]    req_x_addr_i,
   input  logic [Y_W-1:0]    req_y_addr_i,
   input  logic [X_W-1:0]    player_x_i,
   input  logic [Y_W-1:0]    player_y_i,
   input  logic              scroll_en_i,
   vga_pixel_mixer_if.master rom,
   output color_t            rgb_o,
   output logic              h_sync_o,
   output logic              v_sync_o,
   output logic              disp_o
);
   logic                      v_sync_q;
   logic                      frame_evt;
   logic [X_W-1:0]            px_s_q, px_s_d;
   logic [Y_W-1:0]            py_s_q, py_s_d;
   logic [BG_ROW_W-1:0]       scroll_q, scroll_d;
   logic [BG_ROW_W-1:0]       bg_row;
   logic [BG_ADDR_W-1:0]      bg_addr_q, bg_addr_d;
   logic                      hit_a;
   logic [ROM_READ_DELAY-1:1] hit_dly_q;
   logic                      hit_d;
   pix_out_t                  out_q, out_d;

   assign frame_evt = v_sync_q & ~v_sync_i;

   // Player position and scroll only move at frame start so a frame never tears.
   always_comb begin
      px_s_d   = px_s_q;
      py_s_d   = py_s_q;
      scroll_d = scroll_q;
      if (frame_evt) begin
         px_s_d = player_x_i;
         py_s_d = player_y_i;
         if (scroll_en_i)
            scroll_d = (scroll_q == BG_ROW_W'(BG_H - 1)) ? '0 : scroll_q + 1'b1;
      end
   end

   assign bg_row    = bg_row_wrap(req_y_addr_i[Y_W-1:2], scroll_q);
   assign bg_addr_d = BG_ADDR_W'(bg_row) * BG_ADDR_W'(BG_W) + BG_ADDR_W'(req_x_addr_i[X_W-1:2]);

   vga_pixel_mixer_sprite_hit_addr u_player (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_x_i    (req_x_addr_i),
      .req_y_i    (req_y_addr_i),
      .pos_x_i    (px_s_q),
      .pos_y_i    (py_s_q),
      .hit_o      (hit_a),
      .spr_addr_o (rom.spr_addr)
   );

   assign hit_d = hit_dly_q[ROM_READ_DELAY-1];

   always_comb begin
      out_d.h_sync = h_sync_i;
      out_d.v_sync = v_sync_i;
      out_d.disp   = disp_i;
      out_d.rgb    = '0;
      if (disp_i)
         out_d.rgb = (hit_d && rom.spr_data != KEY_COLOR) ? rom.spr_data : rom.bg_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_sync_q  <= 1'b1;
         px_s_q    <= '0;
         py_s_q    <= '0;
         scroll_q  <= '0;
         bg_addr_q <= '0;
         hit_dly_q <= '0;
         out_q     <= PIX_OUT_RESET;
      end else begin
         v_sync_q     <= v_sync_i;
         px_s_q       <= px_s_d;
         py_s_q       <= py_s_d;
         scroll_q     <= scroll_d;
         bg_addr_q    <= bg_addr_d;
         hit_dly_q[1] <= hit_a;
         for (int i = 2; i < ROM_READ_DELAY; i++)
            hit_dly_q[i] <= hit_dly_q[i-1];
         out_q        <= out_d;
      end
   end

   assign rom.bg_addr = bg_addr_q;
   assign rgb_o       = out_q.rgb;
   assign h_sync_o    = out_q.h_sync;
   assign v_sync_o    = out_q.v_sync;
   assign disp_o      = out_q.disp;
endmodule

// File: tb/tb_vga_pixel_mixer.sv
// tb/tb_vga_pixel_mixer.sv - self-checking bench for vga_pixel_mixer
module tb_vga_pixel_mixer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        h_sync_i, v_sync_i, disp_i, scroll_en_i;
   logic [9:0]  req_x_addr_i, player_x_i;
   logic [8:0]  req_y_addr_i, player_y_i;
   logic [11:0] rgb_o;
   logic        h_sync_o, v_sync_o, disp_o;

   vga_pixel_mixer_if rom_bus ();

   vga_pixel_mixer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .h_sync_i     (h_sync_i),
      .v_sync_i     (v_sync_i),
      .disp_i       (disp_i),
      .req_x_addr_i (req_x_addr_i),
      .req_y_addr_i (req_y_addr_i),
      .player_x_i   (player_x_i),
      .player_y_i   (player_y_i),
      .scroll_en_i  (scroll_en_i),
      .rom          (rom_bus.master),
      .rgb_o        (rgb_o),
      .h_sync_o     (h_sync_o),
      .v_sync_o     (v_sync_o),
      .disp_o       (disp_o)
   );

   always #5 clk = ~clk;

   logic [11:0] spr_mem [4096];

   // ROMs: one-cycle synchronous read; background returns its own address as colour.
   always @(posedge clk) begin
      rom_bus.bg_data  <= rom_bus.bg_addr[11:0];
      rom_bus.spr_data <= spr_mem[rom_bus.spr_addr];
   end

   int n_cmp = 0;
   int n_bad = 0;
   int scroll_m, px_m, py_m;
   bit prev_vs_m;
   int exp_rgb_q[$];
   bit vis_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      scroll_m  = 0;
      px_m      = 0;
      py_m      = 0;
      prev_vs_m = 1'b1;
      exp_rgb_q.delete();
      vis_q.delete();
   endtask

   // One pixel request; disp_i for it is presented two cycles later, rgb three cycles later.
   task automatic step(input int x, input int y, input bit vis, input bit hs, input bit vs);
      int row, bga, dx, dy, sa, pix;
      bit hit, d;
      row = ((y / 4) + scroll_m) % 120;
      bga = row * 160 + x / 4;
      dx  = x - px_m;
      dy  = y - py_m;
      hit = (dx >= 0) && (dx < 64) && (dy >= 0) && (dy < 64);
      sa  = hit ? dy * 64 + dx : 0;
      pix = (hit && spr_mem[sa] != 12'h000) ? int'(spr_mem[sa]) : (bga & 'hfff);
      if (!vis) pix = 0;
      if (prev_vs_m && !vs) begin
         px_m = int'(player_x_i);
         py_m = int'(player_y_i);
         if (scroll_en_i) scroll_m = (scroll_m + 1) % 120;
      end
      prev_vs_m = vs;
      vis_q.push_back(vis);
      d = (vis_q.size() > 2) ? vis_q.pop_front() : 1'b0;
      exp_rgb_q.push_back(pix);
      req_x_addr_i = 10'(x);
      req_y_addr_i = 9'(y);
      h_sync_i     = hs;
      v_sync_i     = vs;
      disp_i       = d;
      @(posedge clk);
      #1;
      chk("bg_addr", 32'(rom_bus.bg_addr), bga);
      chk("spr_addr", 32'(rom_bus.spr_addr), sa);
      chk("h_sync", 32'(h_sync_o), 32'(hs));
      chk("v_sync", 32'(v_sync_o), 32'(vs));
      chk("disp", 32'(disp_o), 32'(d));
      if (exp_rgb_q.size() == 3)
         chk("rgb", 32'(rgb_o), exp_rgb_q.pop_front());
   endtask

   task automatic new_frame();
      step(0, 0, 1'b0, 1'b1, 1'b0);
      step(0, 0, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic hold_reset();
      h_sync_i = 1'b1;
      v_sync_i = 1'b1;
      disp_i   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      int x, y;
      for (int i = 0; i < 4096; i++)
         spr_mem[i] = ($urandom % 4 == 0) ? 12'h000 : 12'($urandom);
      spr_mem[0]          = 12'hF00;
      spr_mem[4095]       = 12'h0AB;
      spr_mem[10*64 + 10] = 12'h000;
      spr_mem[39]         = 12'h123;
      spr_mem[29*64 + 39] = 12'h456;
      rom_bus.bg_data  = '0;
      rom_bus.spr_data = '0;
      rst_n = 1'b0;
      req_x_addr_i = '0; req_y_addr_i = '0;
      player_x_i = '0; player_y_i = '0; scroll_en_i = 1'b0;
      hold_reset();
      chk("rst_rgb", 32'(rgb_o), 0);
      chk("rst_hs", 32'(h_sync_o), 1);
      chk("rst_vs", 32'(v_sync_o), 1);
      chk("rst_disp", 32'(disp_o), 0);
      chk("rst_bg_addr", 32'(rom_bus.bg_addr), 0);

      // plain background alignment, sprite parked off-screen
      player_x_i = 10'd700; player_y_i = 9'd0;
      new_frame();
      for (int i = 0; i < 40; i++) step(i * 3, 10 + i, 1'b1, (i % 16) != 0, 1'b1);

      // sprite keying at (100,50)
      player_x_i = 10'd100; player_y_i = 9'd50;
      new_frame();
      step(100, 50, 1'b1, 1'b1, 1'b1);
      step(163, 113, 1'b1, 1'b1, 1'b1);
      step(164, 50, 1'b1, 1'b1, 1'b1);
      step(110, 60, 1'b1, 1'b1, 1'b1);
      step(99, 50, 1'b1, 1'b1, 1'b1);
      step(100, 50, 1'b0, 1'b1, 1'b1);

      // clipping at right/bottom edges
      player_x_i = 10'd600; player_y_i = 9'd450;
      new_frame();
      step(639, 450, 1'b1, 1'b1, 1'b1);
      step(0, 450, 1'b1, 1'b1, 1'b1);
      step(639, 479, 1'b1, 1'b1, 1'b1);
      step(600, 479, 1'b1, 1'b1, 1'b1);
      step(0, 0, 1'b1, 1'b1, 1'b1);

      // mid-frame player change must not take effect until the next frame
      player_x_i = 10'd20; player_y_i = 9'd20;
      step(639, 479, 1'b1, 1'b1, 1'b1);
      step(30, 30, 1'b1, 1'b1, 1'b1);
      new_frame();
      step(639, 479, 1'b1, 1'b1, 1'b1);
      step(30, 30, 1'b1, 1'b1, 1'b1);

      // randomized traffic with occasional frames, scrolling and player moves
      for (int i = 0; i < 400; i++) begin
         if ($urandom % 20 == 0) begin
            player_x_i = 10'($urandom_range(0, 639));
            player_y_i = 9'($urandom_range(0, 479));
         end
         scroll_en_i = 1'($urandom % 2);
         if ($urandom % 2) begin
            x = $urandom_range(0, 639);
            y = $urandom_range(0, 479);
         end else begin
            x = px_m + $urandom_range(0, 79) - 8;
            y = py_m + $urandom_range(0, 79) - 8;
            x = (x < 0) ? 0 : (x > 639) ? 639 : x;
            y = (y < 0) ? 0 : (y > 479) ? 479 : y;
         end
         step(x, y, ($urandom % 8) != 0, ($urandom % 10) != 0, ($urandom % 25) != 0);
      end

      // mid-line asynchronous reset
      scroll_en_i = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      chk("amid_rgb", 32'(rgb_o), 0);
      chk("amid_hs", 32'(h_sync_o), 1);
      chk("amid_vs", 32'(v_sync_o), 1);
      chk("amid_disp", 32'(disp_o), 0);
      chk("amid_bg_addr", 32'(rom_bus.bg_addr), 0);
      hold_reset();

      // scroll wrap: 119 frames reach scroll 119, one more wraps to 0
      player_x_i = 10'd700; player_y_i = 9'd0;
      scroll_en_i = 1'b1;
      for (int i = 0; i < 119; i++) new_frame();
      step(8, 4, 1'b1, 1'b1, 1'b1);
      step(8, 479, 1'b1, 1'b1, 1'b1);
      step(8, 0, 1'b1, 1'b1, 1'b1);
      new_frame();
      step(8, 4, 1'b1, 1'b1, 1'b1);
      step(639, 479, 1'b1, 1'b1, 1'b1);
      scroll_en_i = 1'b0;
      for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
